// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: parity encodings,
// receiver FSM states and the baud-period helper.
package uart_rx_cfg_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } rx_state_t;

   // Clock cycles per serial bit (integer divide).
   function automatic int bit_period(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line in, ready/valid word out, error flags.
// master = the receiver, slave = the consumer (CPU-side register block).
interface uart_rx_if #(parameter int DATA_BITS = 8);

   logic                 serial_in;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_out_valid;
   logic                 data_out_ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;
   logic                 err_clear;
   logic                 busy;

   modport master (
      input  serial_in, data_out_ready, err_clear,
      output data_out, data_out_valid, frame_err, parity_err, overrun, busy
   );

   modport slave (
      output serial_in, data_out_ready, err_clear,
      input  data_out, data_out_valid, frame_err, parity_err, overrun, busy
   );

endinterface

// File: rtl/uart_rx_cfg_sync.sv
// Multi-stage flop synchroniser for asynchronous inputs; resets to all-ones
// so an idle-high line does not look like a start edge after reset.
module synchronizer #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [STAGES-1:0][WIDTH-1:0] sync_d;

   // Shift the input one stage deeper each cycle.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Stage registers with synchronous active-low reset to ones.
   always_ff @(posedge clk) begin
      if (!rst) sync_q <= '1;
      else      sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with a one-entry holding register.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s to fall
// S_START | half-bit wait, re-check start bit to reject glitches
// S_DATA  | sample DATA_BITS payload bits, LSB first, one per bit time
// S_PAR   | sample and check the parity bit
// S_STOP  | sample stop bit(s); commit word on the last one
module uart_rx_cfg
   import uart_rx_cfg_pkg::*;
#(
   parameter int CLOCK_FREQ  = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.master bus
);

   localparam int BIT_T  = bit_period(CLOCK_FREQ, BAUD_RATE);
   localparam int HALF_T = BIT_T / 2;
   localparam int CNT_W  = $clog2(BIT_T);
   localparam int IDX_W  = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_T - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_T - 1);
   localparam logic [IDX_W-1:0] DATA_END = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_END = IDX_W'(STOP_BITS - 1);

   logic                 rx_s;
   rx_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 ferr_pend_q, ferr_pend_d;
   logic                 perr_pend_q, perr_pend_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 ovr_q, ovr_d;
   logic                 commit;

   synchronizer #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.serial_in),
      .q   (rx_s)
   );

   // Frame sequencing plus holding-register load, drain and overrun tracking.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shreg_d     = shreg_q;
      ferr_pend_d = ferr_pend_q;
      perr_pend_d = perr_pend_q;
      dout_d      = dout_q;
      valid_d     = valid_q;
      ferr_d      = ferr_q;
      perr_d      = perr_q;
      ovr_d       = ovr_q;
      commit      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_END) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d     = S_DATA;
                  idx_d       = '0;
                  ferr_pend_d = 1'b0;
                  perr_pend_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
               if (idx_q == DATA_END) begin
                  idx_d   = '0;
                  state_d = (PARITY != PARITY_NONE) ? S_PAR : S_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PAR: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               state_d = S_STOP;
               if (PARITY == PARITY_ODD) perr_pend_d = (rx_s == ^shreg_q);
               else                      perr_pend_d = (rx_s != ^shreg_q);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = '0;
               if (!rx_s) ferr_pend_d = 1'b1;
               if (idx_q == STOP_END) begin
                  idx_d   = '0;
                  state_d = S_IDLE;
                  commit  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (valid_q && bus.data_out_ready) valid_d = 1'b0;
      if (bus.err_clear)                 ovr_d   = 1'b0;

      // A new overrun on the same edge as err_clear still leaves overrun set.
      if (commit) begin
         if (!valid_q || bus.data_out_ready) begin
            dout_d  = shreg_q;
            ferr_d  = ferr_pend_q | ~rx_s;
            perr_d  = perr_pend_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // All receiver state, cleared by synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         ferr_pend_q <= 1'b0;
         perr_pend_q <= 1'b0;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         ferr_q      <= 1'b0;
         perr_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         ferr_pend_q <= ferr_pend_d;
         perr_pend_q <= perr_pend_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         ferr_q      <= ferr_d;
         perr_q      <= perr_d;
         ovr_q       <= ovr_d;
      end
   end

   assign bus.data_out       = dout_q;
   assign bus.data_out_valid = valid_q;
   assign bus.frame_err      = ferr_q;
   assign bus.parity_err     = perr_q;
   assign bus.overrun        = ovr_q;
   assign bus.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) driven in parallel
// with directed and random frames; expected words come from a frame model.
module tb_uart_rx_cfg;

   localparam int CLK_HZ = 50_000_000;
   localparam int BAUD   = 115_200;
   localparam int BIT_T  = CLK_HZ / BAUD;
   localparam int HALF_T = BIT_T / 2;
   localparam int SYNC   = 2;

   typedef struct packed {
      logic [8:0] d;
      logic       fe;
      logic       pe;
   } word_t;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic [2:0] ser   = 3'b111;
   logic [2:0] rdy   = 3'b111;
   logic [2:0] clr   = 3'b000;
   logic [2:0] rst_n = 3'b000;

   logic [2:0][8:0] dout;
   logic [2:0]      vld, fe, pe, ovr, bsy;

   uart_rx_if #(.DATA_BITS(8)) if_a ();
   uart_rx_if #(.DATA_BITS(8)) if_b ();
   uart_rx_if #(.DATA_BITS(7)) if_c ();

   assign if_a.serial_in = ser[0];
   assign if_b.serial_in = ser[1];
   assign if_c.serial_in = ser[2];
   assign if_a.data_out_ready = rdy[0];
   assign if_b.data_out_ready = rdy[1];
   assign if_c.data_out_ready = rdy[2];
   assign if_a.err_clear = clr[0];
   assign if_b.err_clear = clr[1];
   assign if_c.err_clear = clr[2];

   assign dout[0] = {1'b0, if_a.data_out};
   assign dout[1] = {1'b0, if_b.data_out};
   assign dout[2] = {2'b00, if_c.data_out};
   assign vld = {if_c.data_out_valid, if_b.data_out_valid, if_a.data_out_valid};
   assign fe  = {if_c.frame_err,      if_b.frame_err,      if_a.frame_err};
   assign pe  = {if_c.parity_err,     if_b.parity_err,     if_a.parity_err};
   assign ovr = {if_c.overrun,        if_b.overrun,        if_a.overrun};
   assign bsy = {if_c.busy,           if_b.busy,           if_a.busy};

   uart_rx_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .SYNC_STAGES(SYNC))
      dut_a (.clk(clk), .rst(rst_n[0]), .bus(if_a.master));
   uart_rx_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .SYNC_STAGES(SYNC))
      dut_b (.clk(clk), .rst(rst_n[1]), .bus(if_b.master));
   uart_rx_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .SYNC_STAGES(SYNC))
      dut_c (.clk(clk), .rst(rst_n[2]), .bus(if_c.master));

   function automatic int nb(input int d);  return (d == 2) ? 7 : 8; endfunction
   function automatic int par(input int d); return d; endfunction
   function automatic int stb(input int d); return (d == 2) ? 2 : 1; endfunction
   function automatic logic [8:0] mask(input int d);
      return (d == 2) ? 9'h07F : 9'h0FF;
   endfunction

   // Accepted words, captured mid-cycle when valid && ready.
   word_t got0[$], got1[$], got2[$];
   always @(negedge clk) if (vld[0] && rdy[0]) got0.push_back(word_t'{d: dout[0], fe: fe[0], pe: pe[0]});
   always @(negedge clk) if (vld[1] && rdy[1]) got1.push_back(word_t'{d: dout[1], fe: fe[1], pe: pe[1]});
   always @(negedge clk) if (vld[2] && rdy[2]) got2.push_back(word_t'{d: dout[2], fe: fe[2], pe: pe[2]});

   function automatic int qsize(input int d);
      case (d)
         0:       return got0.size();
         1:       return got1.size();
         default: return got2.size();
      endcase
   endfunction

   function automatic word_t qpop(input int d);
      case (d)
         0:       return got0.pop_front();
         1:       return got1.pop_front();
         default: return got2.pop_front();
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input int d, input logic v);
      ser[d] = v;
      tick(BIT_T);
   endtask

   // Sends one frame; par_force < 0 sends the correct parity bit, else its LSB.
   task automatic send_frame(input int d, input logic [8:0] data, input int par_force,
                             input logic stop_first, output word_t exp);
      logic [8:0] m;
      logic good, pbit;
      m    = data & mask(d);
      good = ($countones(m) % 2 == 1);
      if (par(d) == 2) good = !good;
      pbit = (par_force < 0) ? good : par_force[0];
      drive_bit(d, 1'b0);
      for (int i = 0; i < nb(d); i++) drive_bit(d, m[i]);
      if (par(d) != 0) drive_bit(d, pbit);
      drive_bit(d, stop_first);
      for (int i = 1; i < stb(d); i++) drive_bit(d, 1'b1);
      ser[d] = 1'b1;
      exp = word_t'{d: m, fe: !stop_first, pe: (par(d) != 0) && (pbit != good)};
   endtask

   task automatic expect_word(input int d, input word_t exp, input string tag);
      word_t w;
      int n = 0;
      while (qsize(d) == 0 && n < 20) begin
         tick(1);
         n++;
      end
      chk({tag, " present"}, 32'(qsize(d) != 0), 32'd1);
      if (qsize(d) != 0) begin
         w = qpop(d);
         chk({tag, " data"}, 32'(w.d), 32'(exp.d));
         chk({tag, " frame_err"}, 32'(w.fe), 32'(exp.fe));
         chk({tag, " parity_err"}, 32'(w.pe), 32'(exp.pe));
      end
   endtask

   // Common suite for the 8N1 and 7O2 instances.
   task automatic run_suite(input int d, input int nwords);
      word_t e;
      logic [8:0] m;
      for (int i = 0; i < nwords; i++) begin
         m = (d == 0) ? 9'(8'h61 + i) : 9'($urandom_range(0, 511));
         send_frame(d, m, -1, 1'b1, e);
         expect_word(d, e, $sformatf("d%0d b2b%0d", d, i));
      end

      send_frame(d, 9'h055, -1, 1'b0, e);
      expect_word(d, e, $sformatf("d%0d stop_low", d));
      tick(BIT_T);
      send_frame(d, 9'h0A5, -1, 1'b1, e);
      expect_word(d, e, $sformatf("d%0d after_ferr", d));

      ser[d] = 1'b0;
      tick(10);
      ser[d] = 1'b1;
      tick(40);
      chk($sformatf("d%0d glitch busy_hi", d), 32'(bsy[d]), 32'd1);
      tick(HALF_T + SYNC + 2 - 50);
      chk($sformatf("d%0d glitch busy_lo", d), 32'(bsy[d]), 32'd0);
      chk($sformatf("d%0d glitch valid", d), 32'(vld[d]), 32'd0);
      chk($sformatf("d%0d glitch no_word", d), 32'(qsize(d)), 32'd0);

      rdy[d] = 1'b0;
      send_frame(d, 9'h011, -1, 1'b1, e);
      chk($sformatf("d%0d ovr1 valid", d), 32'(vld[d]), 32'd1);
      chk($sformatf("d%0d ovr1 data", d), 32'(dout[d]), 32'h11);
      chk($sformatf("d%0d ovr1 overrun", d), 32'(ovr[d]), 32'd0);
      send_frame(d, 9'h022, -1, 1'b1, e);
      chk($sformatf("d%0d ovr2 data", d), 32'(dout[d]), 32'h11);
      chk($sformatf("d%0d ovr2 overrun", d), 32'(ovr[d]), 32'd1);
      rdy[d] = 1'b1;
      expect_word(d, word_t'{d: 9'h011, fe: 1'b0, pe: 1'b0}, $sformatf("d%0d drain", d));
      chk($sformatf("d%0d drained valid", d), 32'(vld[d]), 32'd0);
      chk($sformatf("d%0d ovr sticky", d), 32'(ovr[d]), 32'd1);
      clr[d] = 1'b1;
      tick(1);
      clr[d] = 1'b0;
      chk($sformatf("d%0d ovr cleared", d), 32'(ovr[d]), 32'd0);

      m = 9'h033;
      drive_bit(d, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d, m[i]);
      ser[d]   = 1'b1;
      rst_n[d] = 1'b0;
      tick(2);
      rst_n[d] = 1'b1;
      chk($sformatf("d%0d midrst busy", d), 32'(bsy[d]), 32'd0);
      tick(2 * BIT_T);
      chk($sformatf("d%0d midrst valid", d), 32'(vld[d]), 32'd0);
      chk($sformatf("d%0d midrst no_word", d), 32'(qsize(d)), 32'd0);
      send_frame(d, 9'h044, -1, 1'b1, e);
      expect_word(d, e, $sformatf("d%0d after_rst", d));
   endtask

   initial begin
      word_t e;
      int pf;
      logic sb;

      tick(3);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d rst data", d), 32'(dout[d]), 32'd0);
         chk($sformatf("d%0d rst valid", d), 32'(vld[d]), 32'd0);
         chk($sformatf("d%0d rst frame_err", d), 32'(fe[d]), 32'd0);
         chk($sformatf("d%0d rst parity_err", d), 32'(pe[d]), 32'd0);
         chk($sformatf("d%0d rst overrun", d), 32'(ovr[d]), 32'd0);
         chk($sformatf("d%0d rst busy", d), 32'(bsy[d]), 32'd0);
      end
      rst_n = 3'b111;
      tick(5);

      fork
         run_suite(0, 10);
         begin
            send_frame(1, 9'h061, 1, 1'b1, e);
            expect_word(1, e, "par first");
            send_frame(1, 9'h061, 0, 1'b1, e);
            expect_word(1, e, "par second");
            for (int i = 0; i < 6; i++) begin
               pf = int'($urandom_range(0, 2)) - 1;
               sb = 1'($urandom_range(0, 3) != 0);
               send_frame(1, 9'($urandom_range(0, 255)), pf, sb, e);
               expect_word(1, e, $sformatf("par rnd%0d", i));
               if (!sb) tick(BIT_T);
            end
         end
         run_suite(2, 4);
      join

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
